alu_ctrl_pipe: RTL and testbench
================================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 1, pipeline depth (legal 1..4).
REQ-002 SHALL have parameter CTRL_W, default 4, Control_out width (legal >=4; codes zero-extended).
REQ-003 SHALL have parameter EXT_EN, default 1, enables extended RV32I ops and ALU_Op=11 I-type decode.
REQ-004 SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-005 SHALL have parameter ERR_W, default 8, illegal-op counter width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  block accepts beat this cycle.
REQ-010 ALU_Op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-011 fun7  in  7  instruction funct7.
REQ-012 fun3  in  3  instruction funct3.
REQ-013 in_tag  in  TAG_W  opaque tag carried with beat.
REQ-014 out_valid  out  1  decoded beat valid.
REQ-015 out_ready  in  1  downstream accepts beat.
REQ-016 Control_out  out  CTRL_W  decoded ALU control code.
REQ-017 illegal  out  1  beat matched no legal decode.
REQ-018 out_tag  out  TAG_W  tag of the output beat.
REQ-019 err_clr  in  1  synchronous clear of err_cnt.
REQ-020 err_cnt  out  ERR_W  saturating count of accepted illegal beats.

Function
REQ-021 Codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-022 ALU_Op=00 SHALL give ADD and ALU_Op=01 SHALL give SUB, regardless of fun7/fun3, and are never illegal.
REQ-023 ALU_Op=10 SHALL decode {fun7,fun3}: 0000000_000 ADD, 0100000_000 SUB, 0000000_111 AND, 0000000_110 OR; with EXT_EN=1 also 0000000_100 XOR, 0000000_001 SLL, 0000000_101 SRL, 0100000_101 SRA, 0000000_010 SLT, 0000000_011 SLTU.
REQ-024 ALU_Op=11 with EXT_EN=1 SHALL decode fun3 only: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU; shifts additionally require fun7=0000000 (001 SLL, 101 SRL) or 0100000 (101 SRA).
REQ-025 Any other combination, including ALU_Op=11 with EXT_EN=0, SHALL give ADD with illegal=1.
REQ-026 Decode SHALL happen at input; the result, illegal and tag SHALL traverse STAGES register stages, giving latency of exactly STAGES cycles with no backpressure.
REQ-027 A beat SHALL transfer when valid and ready are both high on a clock edge, at input and at output.
REQ-028 Stage k SHALL be ready when empty or when stage k+1 (or output) is ready; in_ready SHALL be stage 1 ready (combinational from out_ready through the chain).
REQ-029 With out_ready held low, outputs SHALL hold stable and the block SHALL accept exactly STAGES beats, then drop in_ready.
REQ-030 With in_valid and out_ready continuously high, throughput SHALL be one beat per cycle; no beat is lost or duplicated, and order is preserved.
REQ-031 err_cnt SHALL increment by 1 on each accepted input beat with illegal decode, saturating at all-ones.
REQ-032 err_clr SHALL have priority: an illegal accept in the same cycle as err_clr leaves err_cnt=0.

Reset
REQ-033 rst high SHALL immediately clear all stage valid bits, out_valid=0, Control_out=0, illegal=0, out_tag=0, err_cnt=0.
REQ-034 In-flight beats at reset SHALL be discarded; in_ready SHALL be 1 during and after reset.

Structure
REQ-035 A shared package SHALL hold ALU_Op encodings, the ten ALU control code constants and funct7 constants 0000000/0100000.
REQ-036 Decode SHALL be a combinational sub-module alu_ctrl_decode (parameter EXT_EN) instantiated once before the pipeline.

Verification
REQ-037 STAGES=1: ALU_Op=10, fun7=0100000, fun3=000, tag=5 -> next cycle Control_out=0110, illegal=0, out_tag=5.
REQ-038 STAGES=3, stream 8 back-to-back legal beats with out_ready=1 -> outputs in order, first at cycle 3, one per cycle.
REQ-039 STAGES=2, out_ready=0 -> exactly 2 beats accepted, in_ready=0; raise out_ready -> both emitted in order, none lost.
REQ-040 EXT_EN=0, ALU_Op=11 fun3=000 -> Control_out=0010, illegal=1, err_cnt=1; ERR_W=2 with 5 illegal beats -> err_cnt=3.
REQ-041 Illegal beat accepted with err_clr=1 -> err_cnt=0; rst asserted with 2 beats in flight -> out_valid=0 at once, no beats emitted afterwards.

Source files
------------

// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared encodings for the ALU control decoder and its pipeline:
// ALU_Op classes, ALU control codes and the two funct7 patterns of interest.
package alu_ctrl_pipe_pkg;

  // ALU_Op instruction classes
  localparam logic [1:0] OP_LDST = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_R    = 2'b10;
  localparam logic [1:0] OP_I    = 2'b11;

  // Native 4-bit ALU control codes; wider Control_out zero-extends these
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CTRL_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] CTRL_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] CTRL_XOR  = 4'b0011;
  localparam logic [CODE_W-1:0] CTRL_SLL  = 4'b0100;
  localparam logic [CODE_W-1:0] CTRL_SRL  = 4'b0101;
  localparam logic [CODE_W-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] CTRL_SRA  = 4'b0111;
  localparam logic [CODE_W-1:0] CTRL_SLT  = 4'b1000;
  localparam logic [CODE_W-1:0] CTRL_SLTU = 4'b1001;

  // funct7 patterns: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_ctrl_pipe_decode.sv
// Combinational ALU control decoder. Unmatched encodings fall back to ADD
// and raise o_illegal so the datapath always sees a harmless operation.
module alu_ctrl_decode
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [1:0]        i_alu_op,
  input  logic [6:0]        i_fun7,
  input  logic [2:0]        i_fun3,
  output logic [CODE_W-1:0] o_code,
  output logic              o_illegal
);

  // Decode the instruction class, then funct7/funct3 where they matter
  always_comb begin
    o_code    = CTRL_ADD;
    o_illegal = 1'b0;
    case (i_alu_op)
      OP_LDST: o_code = CTRL_ADD;
      OP_BR:   o_code = CTRL_SUB;
      OP_R: begin
        o_illegal = 1'b1;
        case ({i_fun7, i_fun3})
          {F7_ZERO, 3'b000}: begin o_code = CTRL_ADD; o_illegal = 1'b0; end
          {F7_ALT,  3'b000}: begin o_code = CTRL_SUB; o_illegal = 1'b0; end
          {F7_ZERO, 3'b111}: begin o_code = CTRL_AND; o_illegal = 1'b0; end
          {F7_ZERO, 3'b110}: begin o_code = CTRL_OR;  o_illegal = 1'b0; end
          {F7_ZERO, 3'b100}: if (EXT_EN != 0) begin o_code = CTRL_XOR;  o_illegal = 1'b0; end
          {F7_ZERO, 3'b001}: if (EXT_EN != 0) begin o_code = CTRL_SLL;  o_illegal = 1'b0; end
          {F7_ZERO, 3'b101}: if (EXT_EN != 0) begin o_code = CTRL_SRL;  o_illegal = 1'b0; end
          {F7_ALT,  3'b101}: if (EXT_EN != 0) begin o_code = CTRL_SRA;  o_illegal = 1'b0; end
          {F7_ZERO, 3'b010}: if (EXT_EN != 0) begin o_code = CTRL_SLT;  o_illegal = 1'b0; end
          {F7_ZERO, 3'b011}: if (EXT_EN != 0) begin o_code = CTRL_SLTU; o_illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_I: begin
        o_illegal = 1'b1;
        if (EXT_EN != 0) begin
          // Immediate forms ignore funct7 except for the shifts, where it
          // selects logical vs arithmetic right shift.
          case (i_fun3)
            3'b000: begin o_code = CTRL_ADD;  o_illegal = 1'b0; end
            3'b111: begin o_code = CTRL_AND;  o_illegal = 1'b0; end
            3'b110: begin o_code = CTRL_OR;   o_illegal = 1'b0; end
            3'b100: begin o_code = CTRL_XOR;  o_illegal = 1'b0; end
            3'b010: begin o_code = CTRL_SLT;  o_illegal = 1'b0; end
            3'b011: begin o_code = CTRL_SLTU; o_illegal = 1'b0; end
            3'b001: if (i_fun7 == F7_ZERO) begin o_code = CTRL_SLL; o_illegal = 1'b0; end
            3'b101: begin
              if (i_fun7 == F7_ZERO) begin
                o_code    = CTRL_SRL;
                o_illegal = 1'b0;
              end else if (i_fun7 == F7_ALT) begin
                o_code    = CTRL_SRA;
                o_illegal = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder followed by a STAGES-deep valid/ready register pipeline
// carrying code, illegal flag and tag, plus a saturating illegal-beat counter.
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int CTRL_W = 4,
  parameter int EXT_EN = 1,
  parameter int TAG_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALU_Op,
  input  logic [6:0]        fun7,
  input  logic [2:0]        fun3,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] Control_out,
  output logic              illegal,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              err_clr,
  output logic [ERR_W-1:0]  err_cnt
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_ctrl_pipe: STAGES must be 1..4");
  end
  if (CTRL_W < CODE_W) begin : g_bad_ctrl_w
    $error("alu_ctrl_pipe: CTRL_W must be at least 4");
  end

  logic [CODE_W-1:0] w_dec_code;
  logic              w_dec_ill;
  logic              w_acc;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_src_vld;
  logic [STAGES-1:0] w_src_ill;
  logic [CODE_W-1:0] w_src_code [STAGES];
  logic [TAG_W-1:0]  w_src_tag  [STAGES];

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_ill;
  logic [CODE_W-1:0] r_code [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [ERR_W-1:0]  r_err_cnt;

  alu_ctrl_decode #(
    .EXT_EN(EXT_EN)
  ) u_decode (
    .i_alu_op  (ALU_Op),
    .i_fun7    (fun7),
    .i_fun3    (fun3),
    .o_code    (w_dec_code),
    .o_illegal (w_dec_ill)
  );

  // Ready ripples back from out_ready: a stage can load when it is empty or
  // its occupant leaves on the same edge.
  always_comb begin
    logic w_chain;
    w_chain = out_ready;
    w_rdy   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_chain  = ~r_vld[k] | w_chain;
      w_rdy[k] = w_chain;
    end
  end

  // Source of each stage: decoder output for the first, previous stage otherwise
  always_comb begin
    w_src_vld     = '0;
    w_src_ill     = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_src_code[k] = '0;
      w_src_tag[k]  = '0;
    end
    w_src_vld[0]  = in_valid;
    w_src_ill[0]  = w_dec_ill;
    w_src_code[0] = w_dec_code;
    w_src_tag[0]  = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k]  = r_vld[k-1];
      w_src_ill[k]  = r_ill[k-1];
      w_src_code[k] = r_code[k-1];
      w_src_tag[k]  = r_tag[k-1];
    end
  end

  // Stage registers; payload only captured with a valid beat so a draining
  // output keeps its last value instead of toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_ill <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_code[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_ill[k]  <= w_src_ill[k];
            r_code[k] <= w_src_code[k];
            r_tag[k]  <= w_src_tag[k];
          end
        end
      end
    end
  end

  assign w_acc = in_valid & w_rdy[0];

  // Saturating count of accepted illegal beats; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_dec_ill && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign in_ready    = w_rdy[0];
  assign out_valid   = r_vld[STAGES-1];
  assign illegal     = r_ill[STAGES-1];
  assign out_tag     = r_tag[STAGES-1];
  assign Control_out = CTRL_W'(r_code[STAGES-1]);
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench: a 2-stage EXT_EN=1 instance with a 2-bit error counter,
// and a 1-stage EXT_EN=0 instance for the base-only decode.
module tb_alu_ctrl_pipe;

  localparam int ST = 2;

  typedef struct {
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic       ill;
    logic [3:0] tag;
    int         cyc;
  } exp_t;

  vec_t vecs [26] = '{
    '{2'b00, 7'h55, 3'b101, 4'b0010, 1'b0},
    '{2'b01, 7'h7f, 3'b111, 4'b0110, 1'b0},
    '{2'b10, 7'h00, 3'b000, 4'b0010, 1'b0},
    '{2'b10, 7'h20, 3'b000, 4'b0110, 1'b0},
    '{2'b10, 7'h00, 3'b111, 4'b0000, 1'b0},
    '{2'b10, 7'h00, 3'b110, 4'b0001, 1'b0},
    '{2'b10, 7'h00, 3'b100, 4'b0011, 1'b0},
    '{2'b10, 7'h00, 3'b001, 4'b0100, 1'b0},
    '{2'b10, 7'h00, 3'b101, 4'b0101, 1'b0},
    '{2'b10, 7'h20, 3'b101, 4'b0111, 1'b0},
    '{2'b10, 7'h00, 3'b010, 4'b1000, 1'b0},
    '{2'b10, 7'h00, 3'b011, 4'b1001, 1'b0},
    '{2'b10, 7'h20, 3'b111, 4'b0010, 1'b1},
    '{2'b11, 7'h33, 3'b000, 4'b0010, 1'b0},
    '{2'b11, 7'h7f, 3'b111, 4'b0000, 1'b0},
    '{2'b11, 7'h00, 3'b110, 4'b0001, 1'b0},
    '{2'b11, 7'h12, 3'b100, 4'b0011, 1'b0},
    '{2'b11, 7'h00, 3'b010, 4'b1000, 1'b0},
    '{2'b11, 7'h00, 3'b011, 4'b1001, 1'b0},
    '{2'b11, 7'h00, 3'b001, 4'b0100, 1'b0},
    '{2'b11, 7'h20, 3'b001, 4'b0010, 1'b1},
    '{2'b11, 7'h00, 3'b101, 4'b0101, 1'b0},
    '{2'b11, 7'h20, 3'b101, 4'b0111, 1'b0},
    '{2'b11, 7'h01, 3'b101, 4'b0010, 1'b1},
    '{2'b10, 7'h01, 3'b000, 4'b0010, 1'b1},
    '{2'b10, 7'h20, 3'b001, 4'b0010, 1'b1}
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid, in_ready, out_valid, out_ready, illegal, err_clr;
  logic [1:0] alu_op;
  logic [6:0] fun7;
  logic [2:0] fun3;
  logic [3:0] in_tag, out_tag, ctrl_out;
  logic [1:0] err_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal, b_err_clr;
  logic [1:0] b_alu_op;
  logic [6:0] b_fun7;
  logic [2:0] b_fun3;
  logic [3:0] b_in_tag, b_out_tag, b_ctrl_out;
  logic [7:0] b_err_cnt;

  logic [3:0] cur_code, b_cur_code;
  logic       cur_ill, b_cur_ill, chk_lat;
  logic [1:0] exp_err;
  exp_t       q[$], bq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  alu_ctrl_pipe #(
    .STAGES(ST), .CTRL_W(4), .EXT_EN(1), .TAG_W(4), .ERR_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Op(alu_op), .fun7(fun7), .fun3(fun3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .Control_out(ctrl_out),
    .illegal(illegal), .out_tag(out_tag), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  alu_ctrl_pipe #(
    .STAGES(1), .CTRL_W(4), .EXT_EN(0), .TAG_W(4), .ERR_W(8)
  ) u_dut_base (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ALU_Op(b_alu_op), .fun7(b_fun7), .fun3(b_fun3), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .Control_out(b_ctrl_out),
    .illegal(b_illegal), .out_tag(b_out_tag), .err_clr(b_err_clr), .err_cnt(b_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor / scoreboard: compare presented outputs with the queue head,
  // pop on transfer, push expected results of accepted inputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      bq.delete();
      exp_err = '0;
    end else begin
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out got tag=%0h exp=no beat", out_tag);
        end else begin
          e = q[0];
          chk("ctrl", 32'(ctrl_out), 32'(e.code));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("tag", 32'(out_tag), 32'(e.tag));
          if (out_ready) begin
            if (chk_lat) chk("latency", cyc - e.cyc, ST);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{cur_code, cur_ill, in_tag, cyc});
      if (err_clr) exp_err = '0;
      else if (in_valid && in_ready && cur_ill && exp_err != 2'b11) exp_err++;

      if (b_out_valid) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_spurious_out got tag=%0h exp=no beat", b_out_tag);
        end else begin
          e = bq[0];
          chk("b_ctrl", 32'(b_ctrl_out), 32'(e.code));
          chk("b_illegal", 32'(b_illegal), 32'(e.ill));
          chk("b_tag", 32'(b_out_tag), 32'(e.tag));
          if (b_out_ready) begin
            chk("b_latency", cyc - e.cyc, 1);
            void'(bq.pop_front());
          end
        end
      end
      if (b_in_valid && b_in_ready) bq.push_back('{b_cur_code, b_cur_ill, b_in_tag, cyc});
    end
  end

  task automatic apply(input vec_t v, input logic [3:0] tag, input logic clr);
    alu_op   = v.op;
    fun7     = v.f7;
    fun3     = v.f3;
    in_tag   = tag;
    cur_code = v.code;
    cur_ill  = v.ill;
    err_clr  = clr;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input logic [3:0] tag, input logic clr);
    int n = 0;
    apply(v, tag, clr);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [3:0] tag, input logic [3:0] code, input logic ill);
    b_alu_op   = op;
    b_fun7     = f7;
    b_fun3     = f3;
    b_in_tag   = tag;
    b_cur_code = code;
    b_cur_ill  = ill;
    b_in_valid = 1'b1;
    @(negedge clk);
    chk("b_send_accept", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bq.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size() + bq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, nout, idx;
    logic acc;
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    alu_op = '0; fun7 = '0; fun3 = '0; in_tag = '0;
    cur_code = '0; cur_ill = 1'b0; chk_lat = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0;
    b_alu_op = '0; b_fun7 = '0; b_fun3 = '0; b_in_tag = '0;
    b_cur_code = '0; b_cur_ill = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;

    // Back-to-back stream of every decode vector; 5 illegal saturates at 3
    chk_lat = 1'b1;
    for (int i = 0; i < 26; i++) send(vecs[i], 4'(i), 1'b0);
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    chk("err_saturated", 32'(err_cnt), 32'd3);

    // Backpressure: exactly ST beats accepted, outputs held, then drained in order
    out_ready = 1'b0;
    idx = 2;
    nacc = 0;
    apply(vecs[idx], 4'(idx + 8), 1'b0);
    repeat (6) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        idx++;
        apply(vecs[idx], 4'(idx + 8), 1'b0);
      end
    end
    chk("bp_accepts", nacc, ST);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Clear has priority over an illegal accept in the same cycle
    send(vecs[12], 4'h1, 1'b1);
    chk("err_clr_priority", 32'(err_cnt), 32'd0);
    send(vecs[24], 4'h2, 1'b0);
    in_valid = 1'b0;
    chk("err_after_clr", 32'(err_cnt), 32'd1);
    drain();

    // Base-only instance: I-type and extended R-type are illegal
    b_send(2'b10, 7'h20, 3'b000, 4'h5, 4'b0110, 1'b0);
    b_send(2'b11, 7'h00, 3'b000, 4'h6, 4'b0010, 1'b1);
    chk("b_err_one", 32'(b_err_cnt), 32'd1);
    b_send(2'b10, 7'h00, 3'b100, 4'h7, 4'b0010, 1'b1);
    b_send(2'b10, 7'h00, 3'b110, 4'h8, 4'b0001, 1'b0);
    drain();
    chk("b_err_two", 32'(b_err_cnt), 32'd2);

    // Reset with two beats in flight discards them immediately
    out_ready = 1'b0;
    send(vecs[5], 4'h3, 1'b0);
    send(vecs[6], 4'h4, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("inflight_rst_out_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_in_ready", 32'(in_ready), 32'd1);
    chk("inflight_rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("inflight_rst_err", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    nout = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    chk("post_rst_no_output", nout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
